// File: rtl/prog_loader.sv
// prog_loader: streams a program image into byte RAM, then serves CPU code
// fetches with one-cycle registered latency. Holds the CPU in reset until an
// image is resident.
module prog_loader #(
  parameter int AW    = 6,
  parameter int EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AW:0]               load_base,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic                      cpu_reset,
  output logic                      load_done,
  output logic                      load_error,
  input  logic [AW:0]               mem_addr,
  input  logic [EXTRA-1:0]          mem_extra,
  output logic [(2**EXTRA)*8-1:0]   mem_data,
  output logic                      mem_error,
  output logic [AW:0]               lower_bound,
  output logic [AW:0]               upper_bound
);

  localparam int DEPTH = 2**(AW+1);
  localparam int NB    = 2**EXTRA;
  localparam int DW    = NB*8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FAULT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     lower_bound_q, lower_bound_d;
  logic [AW:0]     upper_bound_q, upper_bound_d;
  logic            load_error_q, load_error_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic            mem_error_q, mem_error_d;
  logic            ram_we;
  logic [AW+1:0]   rd_sum;
  logic [7:0]      ram_q [DEPTH];

  // Control state and load bookkeeping registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      lower_bound_q <= '0;
      upper_bound_q <= '0;
      load_error_q  <= 1'b0;
      mem_data_q    <= '0;
      mem_error_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      lower_bound_q <= lower_bound_d;
      upper_bound_q <= upper_bound_d;
      load_error_q  <= load_error_d;
      mem_data_q    <= mem_data_d;
      mem_error_q   <= mem_error_d;
    end
  end

  // Image RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[wr_ptr_q] <= in_data;
  end

  // Load FSM: next state, write pointer, bounds and stream handshake
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    lower_bound_d = lower_bound_q;
    upper_bound_d = upper_bound_q;
    load_error_d  = load_error_q;
    ram_we        = 1'b0;
    in_ready      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_LOAD;
          wr_ptr_d      = load_base;
          lower_bound_d = load_base;
          load_error_d  = 1'b0;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ram_we = 1'b1;
          if (in_last) begin
            upper_bound_d = wr_ptr_q;
            state_d       = S_DONE;
          end else if (wr_ptr_q == '1) begin
            // Top of RAM reached with more bytes pending: no wrap to 0
            state_d = S_FAULT;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      S_FAULT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_d      = S_IDLE;
          load_error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch port: bounds check in AW+2 bits, little-endian byte gather
  always_comb begin
    rd_sum      = {1'b0, mem_addr} + (AW+2)'(mem_extra);
    mem_error_d = (state_q != S_DONE) || (mem_addr < lower_bound_q) ||
                  (rd_sum > {1'b0, upper_bound_q});
    mem_data_d  = '0;
    if (!mem_error_d) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (i <= 32'(mem_extra))
          mem_data_d[8*i +: 8] = ram_q[mem_addr + (AW+1)'(i)];
      end
    end
  end

  assign cpu_reset   = (state_q != S_DONE);
  assign load_done   = (state_q == S_DONE);
  assign load_error  = load_error_q;
  assign lower_bound = lower_bound_q;
  assign upper_bound = upper_bound_q;
  assign mem_data    = mem_data_q;
  assign mem_error   = mem_error_q;

endmodule
